// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that shares one AdditionStage32 adder between two requesters.
// Sequences load/en, waits for a fresh ready (with timeout) and returns the result to the issuer.
module fp_add_arbiter #(
    parameter int LOAD_CYCLES = 2,
    parameter int MIN_WAIT    = 1,
    parameter int TIMEOUT     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [1:0]  req_sub,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        add_en,
    output logic        add_load,
    output logic        add_pm,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_ready
);
    localparam int CMAX = (TIMEOUT > LOAD_CYCLES) ? TIMEOUT : LOAD_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_MIN  = CW'(MIN_WAIT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0]   QNAN      = 32'h7FC0_0000;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          last_grant;
    logic          to_flag;
    logic          sel;
    logic          take;

    // Accept is offered only in IDLE; a tie goes to the requester not served last.
    always_comb begin
        sel       = 1'b0;
        req_ready = 2'b00;
        if (rst && state == S_IDLE) begin
            case (req_valid)
                2'b01: begin
                    sel       = 1'b0;
                    req_ready = 2'b01;
                end
                2'b10: begin
                    sel       = 1'b1;
                    req_ready = 2'b10;
                end
                2'b11: begin
                    sel       = ~last_grant;
                    req_ready = last_grant ? 2'b01 : 2'b10;
                end
                default: begin
                    sel       = 1'b0;
                    req_ready = 2'b00;
                end
            endcase
        end
    end

    assign take = |req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            to_flag    <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            add_pm     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        add_a  <= sel ? req_a[63:32] : req_a[31:0];
                        add_b  <= sel ? req_b[63:32] : req_b[31:0];
                        add_pm <= req_sub[sel];
                        grant  <= sel;
                        cnt    <= '0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt == LOAD_LAST) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    // Ready in the first MIN_WAIT cycles may be left over from the previous op.
                    if (cnt >= WAIT_MIN && add_ready) begin
                        rsp_data <= add_sum;
                        to_flag  <= 1'b0;
                        state    <= S_RESP;
                    end else if (cnt == WAIT_LAST) begin
                        rsp_data <= QNAN;
                        to_flag  <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    last_grant <= grant;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign add_en      = (state == S_LOAD) || (state == S_WAIT);
    assign add_load    = (state == S_LOAD);
    assign add_cin     = 1'b0;
    assign rsp_valid   = (state == S_RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_timeout = (state == S_RESP) && to_flag;

endmodule
